// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the multi-channel byte-serial memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;

    localparam logic [31:0] DEF_IO_MASK = 32'h0003_0000;

    // Channel-index width; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin picker: search starts one past the last grant.
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]          req,
    input  logic [ch_w(NUM_CH)-1:0]    last_grant,
    output logic [NUM_CH-1:0]          grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = (32'(last_grant) + i) % NUM_CH;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin multi-channel arbiter over a single 8-bit RAM port with
// little-endian multi-byte assembly, IO back-pressure and flush handling.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                NUM_CH  = 2,
    parameter int                ADDR_W  = 32,
    parameter int                XLEN    = 32,
    parameter logic [ADDR_W-1:0] IO_MASK = ADDR_W'(DEF_IO_MASK)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic                     io_buffer_full,
    output logic                     ram_rw,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [7:0]               ram_in,
    input  logic [7:0]               ram_out,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [2*NUM_CH-1:0]      req_size,
    input  logic [NUM_CH-1:0]        req_unsigned,
    input  logic [ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [XLEN*NUM_CH-1:0]   req_wdata,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [XLEN-1:0]          resp_data,
    output logic                     busy
);

    localparam int CW = ch_w(NUM_CH);
    localparam int NB = XLEN / 8;

    state_t            state, state_nx;
    logic [CW-1:0]     last_grant, ch;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] base_q;
    logic [XLEN-1:0]   wdata_q, buf_q;
    logic [3:0]        cnt, n_q;

    logic [NUM_CH-1:0] grant;
    logic [ADDR_W-1:0] cur_addr;
    logic              io_stall, grant_ok, accept, sign;
    int unsigned       gi;
    logic [1:0]        sel_size;
    logic [XLEN-1:0]   ext;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        cur_addr = base_q + ADDR_W'(cnt);
        io_stall = we_q && io_buffer_full && ((cur_addr & IO_MASK) == IO_MASK);
        grant_ok = (state == ST_IDLE) && rst_in && rdy_in && !flush_in;
        req_ready = grant_ok ? grant : '0;
        accept   = grant_ok && (grant != '0);
        gi = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) gi = i;
        end
        sel_size = req_size[2*gi +: 2];
        if (XLEN < 64 && sel_size == SZ_DOUBLE) sel_size = SZ_WORD;
    end

    // Bytes beyond the access size are filled from the top captured bit.
    always_comb begin
        unique case (size_q)
            SZ_BYTE: sign = buf_q[7];
            SZ_HALF: sign = buf_q[15];
            SZ_WORD: sign = buf_q[31];
            default: sign = buf_q[XLEN-1];
        endcase
        ext = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            ext[8*k +: 8] = (k < 32'(n_q)) ? buf_q[8*k +: 8] : {8{sign & !uns_q}};
        end
    end

    always_comb begin
        state_nx   = state;
        ram_rw     = 1'b1;
        ram_addr   = '0;
        ram_in     = '0;
        resp_valid = '0;
        resp_data  = '0;
        unique case (state)
            ST_IDLE: if (accept) state_nx = ST_XFER;
            ST_XFER: begin
                ram_addr = cur_addr;
                if (we_q) begin
                    ram_in = wdata_q[8*cnt +: 8];
                    if (!io_stall) begin
                        ram_rw = !rdy_in;
                        if (cnt == n_q - 4'd1) state_nx = ST_RESP;
                    end
                end else if (flush_in) begin
                    state_nx = ST_IDLE;
                end else if (cnt == n_q) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
                if (we_q || !flush_in) begin
                    resp_valid[ch] = rdy_in;
                    resp_data      = we_q ? '0 : ext;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_IDLE;
            last_grant <= CW'(NUM_CH - 1);
            ch         <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            base_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            cnt        <= '0;
            n_q        <= '0;
        end else if (rdy_in) begin
            state <= state_nx;
            unique case (state)
                ST_IDLE: if (accept) begin
                    ch         <= CW'(gi);
                    last_grant <= CW'(gi);
                    we_q       <= req_we[gi];
                    uns_q      <= req_unsigned[gi];
                    size_q     <= sel_size;
                    base_q     <= req_addr[ADDR_W*gi +: ADDR_W];
                    wdata_q    <= req_wdata[XLEN*gi +: XLEN];
                    cnt        <= '0;
                    n_q        <= 4'd1 << sel_size;
                end
                // Loads run one count past n: the last edge only captures.
                ST_XFER: if (we_q) begin
                    if (!io_stall) cnt <= cnt + 4'd1;
                end else if (!flush_in) begin
                    if (cnt != '0) buf_q[8*(cnt-4'd1) +: 8] <= ram_out;
                    if (cnt < n_q) cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
